// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer: chunk width,
// sequencer states and small helpers used by the datapath.
package wide_add_sequencer_pkg;

    localparam int CHUNK_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Operand width for a given number of chunks.
    function automatic int calc_width(input int words);
        return CHUNK_W * words;
    endfunction

    // Carry out of a chunk recovered from the top bits of its inputs and sum:
    // when a6^b6 the sum bit is the inverted carry into bit 6.
    function automatic logic chunk_carry_out(input logic a6, input logic b6, input logic r6);
        return (a6 & b6) | ((a6 ^ b6) & ~r6);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_cla7.sv
// Shared 7-bit carry-lookahead adder; purely combinational, sum only
// (no carry-out port).
module carry_look_ahead_adder7
    import wide_add_sequencer_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum
);

    logic [CHUNK_W-1:0] g_s;
    logic [CHUNK_W-1:0] p_s;
    logic [CHUNK_W:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Flattened lookahead: each carry is the OR of every generate term
    // propagated up to it, plus cin propagated through all lower bits.
    always_comb begin
        logic term_v;
        term_v   = 1'b0;
        c_s      = '0;
        c_s[0]   = cin;
        for (int i = 0; i < CHUNK_W; i++) begin
            term_v = cin;
            for (int j = 0; j <= i; j++) begin
                term_v = term_v & p_s[j];
            end
            c_s[i+1] = term_v;
            for (int k = 0; k <= i; k++) begin
                term_v = g_s[k];
                for (int j = k + 1; j <= i; j++) begin
                    term_v = term_v & p_s[j];
                end
                c_s[i+1] = c_s[i+1] | term_v;
            end
        end
    end

    assign sum = p_s ^ c_s[CHUNK_W-1:0];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WORDS*7-bit add/subtract built on one shared 7-bit adder,
// LSB chunk first. Optional signed overflow flag under OVF_FLAG_EN.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [CHUNK_W*WORDS-1:0] a,
    input  logic [CHUNK_W*WORDS-1:0] b,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [CHUNK_W*WORDS-1:0] result,
    output logic                     cout
`ifdef OVF_FLAG_EN
    ,
    output logic                     ovf
`endif
);

    localparam int W     = calc_width(WORDS);
    localparam int IDX_W = $clog2(WORDS);

    seq_state_e          state_r;
    seq_state_e          state_nxt_s;
    logic                accept_s;
    logic                last_s;
    logic [IDX_W-1:0]    idx_r;
    logic                carry_r;
    logic [W-1:0]        opa_r;
    logic [W-1:0]        opb_r;
    logic [W-1:0]        result_r;
    logic                cout_r;
    logic [CHUNK_W-1:0]  chunk_a_s;
    logic [CHUNK_W-1:0]  chunk_b_s;
    logic [CHUNK_W-1:0]  sum_s;
    logic                carry_out_s;

    assign chunk_a_s   = opa_r[CHUNK_W*idx_r +: CHUNK_W];
    assign chunk_b_s   = opb_r[CHUNK_W*idx_r +: CHUNK_W];
    assign last_s      = (idx_r == IDX_W'(WORDS - 1));
    assign carry_out_s = chunk_carry_out(chunk_a_s[CHUNK_W-1], chunk_b_s[CHUNK_W-1],
                                         sum_s[CHUNK_W-1]);

    carry_look_ahead_adder7 u_adder (
        .a   (chunk_a_s),
        .b   (chunk_b_s),
        .cin (carry_r),
        .sum (sum_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and accept decode; DONE may accept a new request directly.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture and per-chunk result/carry update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r    <= '0;
            carry_r  <= 1'b0;
            opa_r    <= '0;
            opb_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else if (accept_s) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= sub;
            idx_r   <= '0;
        end else if (state_r == RUN) begin
            result_r[CHUNK_W*idx_r +: CHUNK_W] <= sum_s;
            carry_r <= carry_out_s;
            if (last_s) begin
                idx_r  <= '0;
                cout_r <= carry_out_s;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
            end
        end
    end

`ifdef OVF_FLAG_EN
    logic ovf_r;
    logic msb_cin_s;

    assign msb_cin_s = chunk_a_s[CHUNK_W-1] ^ chunk_b_s[CHUNK_W-1] ^ sum_s[CHUNK_W-1];

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            ovf_r <= msb_cin_s ^ carry_out_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

    assign ready  = (state_r == IDLE) || (state_r == DONE);
    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign result = result_r;
    assign cout   = cout_r;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle sequencer that performs WORDS*7-bit add/subtract by time-multiplexing one 7-bit carry-lookahead adder, one 7-bit chunk per cycle, LSB chunk first.
- Holds the inter-chunk carry in a register.
- Derives each chunk's carry-out externally, because the 7-bit adder exposes no carry-out.
- Sits between the CPU ALU control and the shared narrow adder; provides wide arithmetic without a wide adder.

Parameters:
WORDS, 4, number of 7-bit chunks; operand width W = 7*WORDS (28 by default). Legal range 2..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- ready  out  1  combinational: high in IDLE or DONE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result/cout valid.
- result  out  W  sum/difference; held until next accepted start.
- cout  out  1  final carry; for sub, 1 = no borrow.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry=0, result=0, cout=0, done=0, busy=0. Applies from any state, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE.
- Accept: at an edge where ready & start are high:
  - latch a into opA;
  - latch (sub ? ~b : b) into opB;
  - carry <= sub; idx <= 0; state <= RUN.
  - result and cout are not cleared at accept. Chunks overwrite result as they are produced.
- RUN, each edge:
  - adder inputs: opA[7*idx+:7], opB[7*idx+:7], cin=carry;
  - result[7*idx+:7] <= adder sum;
  - carry <= (a6&b6) | ((a6^b6) & ~r6), where a6/b6/r6 are bit 6 of the chunk inputs and sum;
  - idx <= idx+1.
  - When idx==WORDS-1: cout <= computed carry; state <= DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN if start is accepted in this cycle (back-to-back).
- Latency: the accept edge is E0; chunks are written at E1..E_WORDS; done is high in the cycle after E_WORDS. Throughput is one op per WORDS+1 cycles.
- start while busy: ignored; no queueing. a/b/sub changes during RUN have no effect (operands are registered).
- Arithmetic is modulo 2^W. Subtract is two's complement (invert B, cin=1).
- The adder is purely combinational; only its chunk result is registered.

Optional Feature:
OVF_FLAG_EN.
- Defined: adds output port ovf (out, 1). It is registered at the final chunk as carry_into_msb ^ carry_out, with carry_into_msb = a6^b6^r6 of the top chunk. ovf is valid with done, reset to 0, and held like result.
- Undefined: no ovf port and no logic.

Decomposition:
- Shared package: state enum {IDLE, RUN, DONE}; CHUNK_W=7 constant; W derivation from WORDS.
- One sub-module: the existing 7-bit carry-lookahead adder (carry_look_ahead_adder7), instantiated once.
- Chunk mux, carry-out derivation and FSM stay in this block.

Test Plan:
1. Basic add: a=0x0000005, b=0x0000003, sub=0 -> done 4 edges after accept; result=0x0000008, cout=0.
2. Full ripple: a=0xFFFFFFF, b=0x0000001, sub=0 -> result=0x0000000, cout=1; carry propagates through all 4 chunks.
3. Subtract:
   - a=0x0000010, b=0x0000001 -> result=0x000000F, cout=1;
   - a=0x0000001, b=0x0000002 -> result=0xFFFFFFF, cout=0.
4. Protocol: start pulsed and a/b changed during RUN -> ignored; result matches the originally latched operands; busy=1 for exactly 4 cycles.
5. Reset mid-op: rst_n=0 at idx=2 -> next cycle: result=0, done=0, ready=1. A following add 0x1234567+0x0000001 -> 0x1234568.
6. Back-to-back plus overflow (OVF_FLAG_EN):
   - start held high across DONE -> second op accepted in the DONE cycle.
   - a=0x7FFFFFF, b=0x0000001 -> ovf=1, result=0x8000000.
   - a=0x0000002, b=0x0000001 -> ovf=0.
